// File: rtl/grf_write_arbiter_pkg.sv
// Shared types and defaults for the GRF write-port arbiter and its MDU result queue.
// Optional build macro GRF_TRACE_EN (used by the top) enables a commit trace in simulation.
package grf_arb_pkg;

  localparam int DEF_DEPTH      = 2;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_MD   = 2'd2
  } src_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } wq_entry_t;

endpackage

// File: rtl/grf_write_arbiter_if.sv
// Bundle of writeback, MDU, GRF-port and hazard-unit signals around the GRF write arbiter.
// The arbiter uses the slave view; the surrounding pipeline uses the master view.
interface grf_write_arbiter_if;

  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;

  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic [31:0] md_pc;

  logic        md_issue;
  logic [4:0]  md_issue_addr;

  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  logic [31:0] pending;
  logic        md_urgent;
  logic        waw_err;

  modport master (
    output wb_we, wb_addr, wb_data, wb_pc,
    output md_valid, md_addr, md_data, md_pc,
    output md_issue, md_issue_addr,
    input  md_ready,
    input  grf_we, grf_a3, grf_wd, grf_pc,
    input  pending, md_urgent, waw_err
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, wb_pc,
    input  md_valid, md_addr, md_data, md_pc,
    input  md_issue, md_issue_addr,
    output md_ready,
    output grf_we, grf_a3, grf_wd, grf_pc,
    output pending, md_urgent, waw_err
  );

endinterface

// File: rtl/grf_write_arbiter_wq.sv
// grf_wq: DEPTH-entry synchronous FIFO holding MDU results until they win the GRF port.
// Head is read combinationally so an entry pushed at one edge can be granted the next cycle.
import grf_arb_pkg::*;

module grf_wq #(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  wq_entry_t din,
  output logic      full,
  output logic      empty,
  output wq_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  wq_entry_t   mem [DEPTH];
  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic        do_push;
  logic        do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// Shares the single GRF write port between writeback (priority) and queued MDU results,
// with a starvation escape, a pending-destination scoreboard and a sticky WAW flag. Macro: GRF_TRACE_EN.
import grf_arb_pkg::*;

module grf_write_arbiter #(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic           clk,
  input logic           reset,
  grf_write_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX - 1);

  wq_entry_t   push_entry;
  wq_entry_t   head;
  logic        full;
  logic        empty;
  logic        head_valid;
  logic        push;
  logic        pop;
  logic        wb_req;
  src_t        src;

  logic [3:0]  starve_reg;
  logic [3:0]  starve_next;
  logic        urgent_reg;
  logic        urgent_next;
  logic [31:0] pending_reg;
  logic [31:0] pending_next;
  logic        waw_reg;
  logic        waw_next;

  assign push_entry  = '{pc: bus.md_pc, addr: bus.md_addr, data: bus.md_data};
  assign bus.md_ready = !full && !reset;
  assign push        = bus.md_valid && bus.md_ready;
  assign head_valid  = !empty;
  assign wb_req      = bus.wb_we && (bus.wb_addr != 5'd0);

  grf_wq #(.DEPTH(DEPTH)) u_wq (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // A forced MDU grant overrides writeback; the pipeline re-presents the held W write.
  always_comb begin
    src = SRC_NONE;
    if (!reset) begin
      if (urgent_reg && head_valid) src = SRC_MD;
      else if (wb_req)              src = SRC_WB;
      else if (head_valid)          src = SRC_MD;
    end
  end

  always_comb begin
    bus.grf_we = 1'b0;
    bus.grf_a3 = 5'd0;
    bus.grf_wd = 32'd0;
    bus.grf_pc = 32'd0;
    pop        = 1'b0;
    unique case (src)
      SRC_WB: begin
        bus.grf_we = 1'b1;
        bus.grf_a3 = bus.wb_addr;
        bus.grf_wd = bus.wb_data;
        bus.grf_pc = bus.wb_pc;
      end
      SRC_MD: begin
        // Entries for $0 still drain in order but never write the register file.
        bus.grf_we = (head.addr != 5'd0);
        bus.grf_a3 = head.addr;
        bus.grf_wd = head.data;
        bus.grf_pc = head.pc;
        pop        = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_next = starve_reg;
    urgent_next = 1'b0;
    if (!head_valid || (src == SRC_MD)) begin
      starve_next = 4'd0;
    end else begin
      if (starve_reg != 4'hF) starve_next = starve_reg + 4'd1;
      urgent_next = (starve_reg == STARVE_LIM);
    end
  end

  // Per-register scoreboard bit: an issue in the same cycle as the retiring grant wins.
  for (genvar gi = 0; gi < 32; gi++) begin : g_pend
    localparam logic [4:0] IDX = 5'(gi);
    logic set_bit;
    logic clr_bit;
    assign set_bit = (IDX != 5'd0) && bus.md_issue && (bus.md_issue_addr == IDX);
    assign clr_bit = (src == SRC_MD) && (head.addr == IDX);
    assign pending_next[gi] = set_bit || (pending_reg[gi] && !clr_bit);
  end

  assign waw_next = waw_reg || (wb_req && pending_reg[bus.wb_addr]);

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_reg  <= 4'd0;
      urgent_reg  <= 1'b0;
      pending_reg <= 32'd0;
      waw_reg     <= 1'b0;
    end else begin
      starve_reg  <= starve_next;
      urgent_reg  <= urgent_next;
      pending_reg <= pending_next;
      waw_reg     <= waw_next;
    end
  end

  assign bus.pending   = pending_reg;
  assign bus.md_urgent = urgent_reg;
  assign bus.waw_err   = waw_reg;

`ifdef GRF_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && bus.grf_we)
      $display("@%h: $%d <= %h", bus.grf_pc, bus.grf_a3, bus.grf_wd);
  end
`endif

endmodule
